// File: rtl/axi_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axi_arbiter
// Purpose  : Shares one AXI4-Lite master port between the IFU (read only) and
//            the LSU (read/write). One transaction at a time, round-robin
//            between requesters, combinational response routing.
// Revision : 1.0 - initial release
// ============================================================================
module axi_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  // IFU read
  input  logic                ifu_ar_valid_i,
  output logic                ifu_ar_ready_o,
  input  logic [ADDR_W-1:0]   ifu_ar_addr_i,
  output logic                ifu_r_valid_o,
  input  logic                ifu_r_ready_i,
  output logic [DATA_W-1:0]   ifu_r_data_o,
  output logic [1:0]          ifu_r_resp_o,
  // LSU read
  input  logic                lsu_ar_valid_i,
  output logic                lsu_ar_ready_o,
  input  logic [ADDR_W-1:0]   lsu_ar_addr_i,
  output logic                lsu_r_valid_o,
  input  logic                lsu_r_ready_i,
  output logic [DATA_W-1:0]   lsu_r_data_o,
  output logic [1:0]          lsu_r_resp_o,
  // LSU write
  input  logic                lsu_aw_valid_i,
  output logic                lsu_aw_ready_o,
  input  logic [ADDR_W-1:0]   lsu_aw_addr_i,
  input  logic                lsu_w_valid_i,
  output logic                lsu_w_ready_o,
  input  logic [DATA_W-1:0]   lsu_w_data_i,
  input  logic [DATA_W/8-1:0] lsu_w_strb_i,
  output logic                lsu_b_valid_o,
  input  logic                lsu_b_ready_i,
  output logic [1:0]          lsu_b_resp_o,
  // Master port
  output logic                mst_ar_valid_o,
  input  logic                mst_ar_ready_i,
  output logic [ADDR_W-1:0]   mst_ar_addr_o,
  input  logic                mst_r_valid_i,
  output logic                mst_r_ready_o,
  input  logic [DATA_W-1:0]   mst_r_data_i,
  input  logic [1:0]          mst_r_resp_i,
  output logic                mst_aw_valid_o,
  input  logic                mst_aw_ready_i,
  output logic [ADDR_W-1:0]   mst_aw_addr_o,
  output logic                mst_w_valid_o,
  input  logic                mst_w_ready_i,
  output logic [DATA_W-1:0]   mst_w_data_o,
  output logic [DATA_W/8-1:0] mst_w_strb_o,
  input  logic                mst_b_valid_i,
  output logic                mst_b_ready_o,
  input  logic [1:0]          mst_b_resp_i
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_REQ  = 3'd3,
    WR_RESP = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic                r_owner_lsu;
  logic                r_prio_lsu;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W/8-1:0] r_wstrb;
  logic                r_aw_done;
  logic                r_w_done;

  logic w_lsu_wr;
  logic w_lsu_rd;
  logic w_lsu_req;
  logic w_pick_lsu;
  logic w_grant;
  logic w_aw_fire;
  logic w_w_fire;
  logic w_b_fire;

  // A complete write (address and data both offered) takes precedence over a read.
  assign w_lsu_wr   = lsu_aw_valid_i & lsu_w_valid_i;
  assign w_lsu_rd   = lsu_ar_valid_i & ~w_lsu_wr;
  assign w_lsu_req  = w_lsu_wr | w_lsu_rd;
  assign w_pick_lsu = w_lsu_req & (~ifu_ar_valid_i | r_prio_lsu);
  // Reset gates the grant so no ready leaks out while reset is held.
  assign w_grant    = (r_state == IDLE) & rst_i & (ifu_ar_valid_i | w_lsu_req);

  assign w_aw_fire  = (r_state == WR_REQ) & ~r_aw_done & mst_aw_ready_i;
  assign w_w_fire   = (r_state == WR_REQ) & ~r_w_done & mst_w_ready_i;
  assign w_b_fire   = (r_state == WR_RESP) & mst_b_valid_i & lsu_b_ready_i;

  // Address/data channels come from registers; responses are pass-through.
  assign mst_ar_addr_o = r_addr;
  assign mst_aw_addr_o = r_addr;
  assign mst_w_data_o  = r_wdata;
  assign mst_w_strb_o  = r_wstrb;
  assign ifu_r_data_o  = mst_r_data_i;
  assign ifu_r_resp_o  = mst_r_resp_i;
  assign lsu_r_data_o  = mst_r_data_i;
  assign lsu_r_resp_o  = mst_r_resp_i;
  assign lsu_b_resp_o  = mst_b_resp_i;

  // State register; reset drops any in-flight transaction.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state, handshake and response-routing logic.
  always_comb begin
    w_next_state   = r_state;
    ifu_ar_ready_o = 1'b0;
    lsu_ar_ready_o = 1'b0;
    lsu_aw_ready_o = 1'b0;
    lsu_w_ready_o  = 1'b0;
    ifu_r_valid_o  = 1'b0;
    lsu_r_valid_o  = 1'b0;
    lsu_b_valid_o  = 1'b0;
    mst_ar_valid_o = 1'b0;
    mst_r_ready_o  = 1'b0;
    mst_aw_valid_o = 1'b0;
    mst_w_valid_o  = 1'b0;
    mst_b_ready_o  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_grant) begin
          if (!w_pick_lsu) begin
            ifu_ar_ready_o = 1'b1;
            w_next_state   = RD_ADDR;
          end else if (w_lsu_wr) begin
            lsu_aw_ready_o = 1'b1;
            lsu_w_ready_o  = 1'b1;
            w_next_state   = WR_REQ;
          end else begin
            lsu_ar_ready_o = 1'b1;
            w_next_state   = RD_ADDR;
          end
        end
      end
      RD_ADDR: begin
        mst_ar_valid_o = 1'b1;
        if (mst_ar_ready_i) w_next_state = RD_DATA;
      end
      RD_DATA: begin
        ifu_r_valid_o = mst_r_valid_i & ~r_owner_lsu;
        lsu_r_valid_o = mst_r_valid_i & r_owner_lsu;
        mst_r_ready_o = r_owner_lsu ? lsu_r_ready_i : ifu_r_ready_i;
        if (mst_r_valid_i && mst_r_ready_o) w_next_state = IDLE;
      end
      WR_REQ: begin
        mst_aw_valid_o = ~r_aw_done;
        mst_w_valid_o  = ~r_w_done;
        if ((r_aw_done || w_aw_fire) && (r_w_done || w_w_fire)) w_next_state = WR_RESP;
      end
      WR_RESP: begin
        lsu_b_valid_o = mst_b_valid_i;
        mst_b_ready_o = lsu_b_ready_i;
        if (w_b_fire) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Request capture at grant, round-robin pointer and write-handshake flags.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_owner_lsu <= 1'b0;
      r_prio_lsu  <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
    end else begin
      if (w_grant) begin
        r_owner_lsu <= w_pick_lsu;
        r_prio_lsu  <= ~w_pick_lsu;
        if (!w_pick_lsu) begin
          r_addr <= ifu_ar_addr_i;
        end else if (w_lsu_wr) begin
          r_addr  <= lsu_aw_addr_i;
          r_wdata <= lsu_w_data_i;
          r_wstrb <= lsu_w_strb_i;
        end else begin
          r_addr <= lsu_ar_addr_i;
        end
      end
      if (w_b_fire) begin
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end else begin
        if (w_aw_fire) r_aw_done <= 1'b1;
        if (w_w_fire)  r_w_done  <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_arbiter
// Purpose  : Directed, table-driven self-checking bench for axi_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_arbiter;

  logic        clk_i, rst_i;
  logic        ifu_ar_valid_i, ifu_ar_ready_o, ifu_r_valid_o, ifu_r_ready_i;
  logic [31:0] ifu_ar_addr_i, ifu_r_data_o;
  logic [1:0]  ifu_r_resp_o;
  logic        lsu_ar_valid_i, lsu_ar_ready_o, lsu_r_valid_o, lsu_r_ready_i;
  logic [31:0] lsu_ar_addr_i, lsu_r_data_o;
  logic [1:0]  lsu_r_resp_o;
  logic        lsu_aw_valid_i, lsu_aw_ready_o, lsu_w_valid_i, lsu_w_ready_o;
  logic [31:0] lsu_aw_addr_i, lsu_w_data_i;
  logic [3:0]  lsu_w_strb_i;
  logic        lsu_b_valid_o, lsu_b_ready_i;
  logic [1:0]  lsu_b_resp_o;
  logic        mst_ar_valid_o, mst_ar_ready_i, mst_r_valid_i, mst_r_ready_o;
  logic [31:0] mst_ar_addr_o, mst_r_data_i;
  logic [1:0]  mst_r_resp_i;
  logic        mst_aw_valid_o, mst_aw_ready_i, mst_w_valid_o, mst_w_ready_i;
  logic [31:0] mst_aw_addr_o, mst_w_data_o;
  logic [3:0]  mst_w_strb_o;
  logic        mst_b_valid_i, mst_b_ready_o;
  logic [1:0]  mst_b_resp_i;

  int n_checks = 0;
  int n_errors = 0;

  axi_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ifu_ar_valid_i(ifu_ar_valid_i), .ifu_ar_ready_o(ifu_ar_ready_o), .ifu_ar_addr_i(ifu_ar_addr_i),
    .ifu_r_valid_o(ifu_r_valid_o), .ifu_r_ready_i(ifu_r_ready_i), .ifu_r_data_o(ifu_r_data_o),
    .ifu_r_resp_o(ifu_r_resp_o),
    .lsu_ar_valid_i(lsu_ar_valid_i), .lsu_ar_ready_o(lsu_ar_ready_o), .lsu_ar_addr_i(lsu_ar_addr_i),
    .lsu_r_valid_o(lsu_r_valid_o), .lsu_r_ready_i(lsu_r_ready_i), .lsu_r_data_o(lsu_r_data_o),
    .lsu_r_resp_o(lsu_r_resp_o),
    .lsu_aw_valid_i(lsu_aw_valid_i), .lsu_aw_ready_o(lsu_aw_ready_o), .lsu_aw_addr_i(lsu_aw_addr_i),
    .lsu_w_valid_i(lsu_w_valid_i), .lsu_w_ready_o(lsu_w_ready_o), .lsu_w_data_i(lsu_w_data_i),
    .lsu_w_strb_i(lsu_w_strb_i),
    .lsu_b_valid_o(lsu_b_valid_o), .lsu_b_ready_i(lsu_b_ready_i), .lsu_b_resp_o(lsu_b_resp_o),
    .mst_ar_valid_o(mst_ar_valid_o), .mst_ar_ready_i(mst_ar_ready_i), .mst_ar_addr_o(mst_ar_addr_o),
    .mst_r_valid_i(mst_r_valid_i), .mst_r_ready_o(mst_r_ready_o), .mst_r_data_i(mst_r_data_i),
    .mst_r_resp_i(mst_r_resp_i),
    .mst_aw_valid_o(mst_aw_valid_o), .mst_aw_ready_i(mst_aw_ready_i), .mst_aw_addr_o(mst_aw_addr_o),
    .mst_w_valid_o(mst_w_valid_o), .mst_w_ready_i(mst_w_ready_i), .mst_w_data_o(mst_w_data_o),
    .mst_w_strb_o(mst_w_strb_o),
    .mst_b_valid_i(mst_b_valid_i), .mst_b_ready_o(mst_b_ready_o), .mst_b_resp_i(mst_b_resp_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // req = {ifu_ar, lsu_ar, lsu_aw, lsu_w}; slv = {ar_rdy, r_vld, aw_rdy, w_rdy, b_vld}
  // exp = {ifu_arr, lsu_arr, lsu_awr, lsu_wr, m_arv, m_awv, m_wv, ifu_rv, lsu_rv, lsu_bv, m_rr, m_br}
  typedef struct {
    logic [3:0]  req;
    logic [4:0]  slv;
    logic [11:0] exp;
    logic [31:0] addr;
  } vec_t;

  localparam int NVEC = 31;
  vec_t vecs [NVEC];

  function automatic logic [11:0] hs_vec();
    return {ifu_ar_ready_o, lsu_ar_ready_o, lsu_aw_ready_o, lsu_w_ready_o,
            mst_ar_valid_o, mst_aw_valid_o, mst_w_valid_o,
            ifu_r_valid_o, lsu_r_valid_o, lsu_b_valid_o, mst_r_ready_o, mst_b_ready_o};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic quiet_inputs();
    ifu_ar_valid_i = 0; lsu_ar_valid_i = 0; lsu_aw_valid_i = 0; lsu_w_valid_i = 0;
    mst_ar_ready_i = 0; mst_r_valid_i = 0; mst_aw_ready_i = 0; mst_w_ready_i = 0;
    mst_b_valid_i = 0;
  endtask

  // Complete IFU read against a zero-wait slave, checking each phase.
  task automatic ifu_read(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk_i);
    ifu_ar_valid_i = 1; ifu_ar_addr_i = addr; mst_ar_ready_i = 1; mst_r_valid_i = 0;
    #1 check("ifu_ar_ready_grant", ifu_ar_ready_o, 1);
    @(negedge clk_i);
    ifu_ar_valid_i = 0;
    #1 check("ifu_mst_ar_valid", mst_ar_valid_o, 1);
    check("ifu_mst_ar_addr", mst_ar_addr_o, addr);
    @(negedge clk_i);
    mst_r_valid_i = 1; mst_r_data_i = data; mst_r_resp_i = 2'b00;
    #1 check("ifu_r_valid", ifu_r_valid_o, 1);
    check("ifu_r_data", ifu_r_data_o, data);
    check("ifu_r_resp", ifu_r_resp_o, 0);
    check("ifu_read_lsu_r_valid", lsu_r_valid_o, 0);
    @(negedge clk_i);
    mst_r_valid_i = 0;
    #1 check("ifu_read_back_idle", {20'd0, hs_vec()}, 0);
  endtask

  initial begin
    vecs[0]  = '{4'b1100, 5'b11000, 12'b1000_000_000_00, 32'h0};
    vecs[1]  = '{4'b1100, 5'b11000, 12'b0000_100_000_00, 32'h8000_0000};
    vecs[2]  = '{4'b1100, 5'b11000, 12'b0000_000_100_10, 32'h0};
    vecs[3]  = '{4'b1100, 5'b11000, 12'b0100_000_000_00, 32'h0};
    vecs[4]  = '{4'b1100, 5'b11000, 12'b0000_100_000_00, 32'h0000_2000};
    vecs[5]  = '{4'b1100, 5'b11000, 12'b0000_000_010_10, 32'h0};
    vecs[6]  = '{4'b1100, 5'b11000, 12'b1000_000_000_00, 32'h0};
    vecs[7]  = '{4'b1100, 5'b11000, 12'b0000_100_000_00, 32'h8000_0000};
    vecs[8]  = '{4'b1100, 5'b11000, 12'b0000_000_100_10, 32'h0};
    vecs[9]  = '{4'b1100, 5'b11000, 12'b0100_000_000_00, 32'h0};
    vecs[10] = '{4'b0000, 5'b11000, 12'b0000_100_000_00, 32'h0000_2000};
    vecs[11] = '{4'b0000, 5'b11000, 12'b0000_000_010_10, 32'h0};
    // LSU write and read together: write wins, wready held low after awready
    vecs[12] = '{4'b0111, 5'b00000, 12'b0011_000_000_00, 32'h0};
    vecs[13] = '{4'b0111, 5'b00100, 12'b0000_011_000_00, 32'h8000_1000};
    vecs[14] = '{4'b0111, 5'b00100, 12'b0000_001_000_00, 32'h0};
    vecs[15] = '{4'b0111, 5'b00100, 12'b0000_001_000_00, 32'h0};
    vecs[16] = '{4'b0111, 5'b00100, 12'b0000_001_000_00, 32'h0};
    vecs[17] = '{4'b0111, 5'b00110, 12'b0000_001_000_00, 32'h0};
    vecs[18] = '{4'b0111, 5'b00000, 12'b0000_000_000_01, 32'h0};
    vecs[19] = '{4'b0100, 5'b00001, 12'b0000_000_001_01, 32'h0};
    vecs[20] = '{4'b0100, 5'b00000, 12'b0100_000_000_00, 32'h0};
    // Master valid held while requester drops, slave stalls ar and r
    vecs[21] = '{4'b0000, 5'b00000, 12'b0000_100_000_00, 32'h0000_2000};
    vecs[22] = '{4'b0000, 5'b10000, 12'b0000_100_000_00, 32'h0000_2000};
    vecs[23] = '{4'b0000, 5'b00000, 12'b0000_000_000_10, 32'h0};
    vecs[24] = '{4'b0000, 5'b01000, 12'b0000_000_010_10, 32'h0};
    vecs[25] = '{4'b0000, 5'b00000, 12'b0000_000_000_00, 32'h0};
    // Write with aw and w handshaking in the same cycle; b delivered once
    vecs[26] = '{4'b0011, 5'b00000, 12'b0011_000_000_00, 32'h0};
    vecs[27] = '{4'b0011, 5'b00110, 12'b0000_011_000_00, 32'h8000_1000};
    vecs[28] = '{4'b0000, 5'b00001, 12'b0000_000_001_01, 32'h0};
    // Half a write (aw or w alone) is not a candidate
    vecs[29] = '{4'b0010, 5'b00000, 12'b0000_000_000_00, 32'h0};
    vecs[30] = '{4'b0001, 5'b00000, 12'b0000_000_000_00, 32'h0};

    quiet_inputs();
    ifu_ar_addr_i = 32'h8000_0000; lsu_ar_addr_i = 32'h0000_2000;
    lsu_aw_addr_i = 32'h8000_1000; lsu_w_data_i = 32'hDEAD_BEEF; lsu_w_strb_i = 4'hF;
    ifu_r_ready_i = 1; lsu_r_ready_i = 1; lsu_b_ready_i = 1;
    mst_r_data_i = 32'h0; mst_r_resp_i = 2'b00; mst_b_resp_i = 2'b00;
    rst_i = 0;

    #3;
    check("reset_handshakes", {20'd0, hs_vec()}, 0);
    check("reset_ar_addr", mst_ar_addr_o, 0);
    check("reset_w_data", mst_w_data_o, 0);
    check("reset_w_strb", {28'd0, mst_w_strb_o}, 0);
    @(negedge clk_i);
    rst_i = 1;

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk_i);
      {ifu_ar_valid_i, lsu_ar_valid_i, lsu_aw_valid_i, lsu_w_valid_i} = vecs[i].req;
      {mst_ar_ready_i, mst_r_valid_i, mst_aw_ready_i, mst_w_ready_i, mst_b_valid_i} = vecs[i].slv;
      #1;
      check($sformatf("vec%0d_handshake", i), {20'd0, hs_vec()}, {20'd0, vecs[i].exp});
      if (vecs[i].exp[7]) check($sformatf("vec%0d_ar_addr", i), mst_ar_addr_o, vecs[i].addr);
      if (vecs[i].exp[6]) check($sformatf("vec%0d_aw_addr", i), mst_aw_addr_o, vecs[i].addr);
      if (vecs[i].exp[5]) begin
        check($sformatf("vec%0d_w_data", i), mst_w_data_o, 32'hDEAD_BEEF);
        check($sformatf("vec%0d_w_strb", i), {28'd0, mst_w_strb_o}, 32'hF);
      end
      if (vecs[i].exp[2]) check($sformatf("vec%0d_b_resp", i), {30'd0, lsu_b_resp_o}, 0);
    end

    quiet_inputs();
    ifu_read(32'h8000_0000, 32'h0000_0413);

    // LSU read with SLVERR: data and resp forwarded unchanged to LSU only
    @(negedge clk_i);
    lsu_ar_valid_i = 1; lsu_ar_addr_i = 32'h0000_3000; mst_ar_ready_i = 1;
    #1 check("lsu_err_ar_ready", lsu_ar_ready_o, 1);
    @(negedge clk_i);
    lsu_ar_valid_i = 0;
    #1 check("lsu_err_ar_addr", mst_ar_addr_o, 32'h0000_3000);
    @(negedge clk_i);
    mst_r_valid_i = 1; mst_r_data_i = 32'h22; mst_r_resp_i = 2'b10;
    #1 check("lsu_err_r_valid", lsu_r_valid_o, 1);
    check("lsu_err_r_data", lsu_r_data_o, 32'h22);
    check("lsu_err_r_resp", {30'd0, lsu_r_resp_o}, 2);
    check("lsu_err_ifu_r_valid", ifu_r_valid_o, 0);
    @(negedge clk_i);
    mst_r_valid_i = 0; mst_r_resp_i = 2'b00;
    #1 check("lsu_err_back_idle", {20'd0, hs_vec()}, 0);

    // Reset while stalled in RD_DATA, requesters still asking
    @(negedge clk_i);
    ifu_ar_valid_i = 1; ifu_ar_addr_i = 32'h8000_0004; mst_ar_ready_i = 1;
    #1 check("rst_seq_grant", ifu_ar_ready_o, 1);
    @(negedge clk_i);
    ifu_ar_valid_i = 0;
    @(negedge clk_i);
    #1 check("rst_seq_in_rd_data", mst_r_ready_o, 1);
    #2;
    ifu_ar_valid_i = 1; lsu_ar_valid_i = 1; rst_i = 0;
    #1 check("rst_midflight_outputs", {20'd0, hs_vec()}, 0);
    @(negedge clk_i);
    ifu_ar_valid_i = 0; lsu_ar_valid_i = 0;
    #1 check("rst_held_outputs", {20'd0, hs_vec()}, 0);
    rst_i = 1;
    ifu_read(32'h8000_0008, 32'h0000_0013);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axi_arbiter.md
# axi_arbiter

Shares the core's single AXI4-Lite master port between the instruction fetch unit (read-only) and the load/store unit (read and write). It sits between `ifu`/`lsu` and the `io_master_*` bus in `top`. It grants one transaction at a time, latches the request, drives the master address/data channels from registers, and routes the response back to the owner. It gives round-robin fairness between IFU and LSU under contention.

## Interface
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width; strobe width is DATA_W/8

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-low
- ifu_ar_valid_i / ifu_ar_ready_o / ifu_ar_addr_i  in/out/in  1/1/ADDR_W  IFU read address
- ifu_r_valid_o / ifu_r_ready_i / ifu_r_data_o / ifu_r_resp_o  out/in/out/out  1/1/DATA_W/2  IFU read response
- lsu_ar_valid_i / lsu_ar_ready_o / lsu_ar_addr_i  in/out/in  1/1/ADDR_W  LSU read address
- lsu_r_valid_o / lsu_r_ready_i / lsu_r_data_o / lsu_r_resp_o  out/in/out/out  1/1/DATA_W/2  LSU read response
- lsu_aw_valid_i / lsu_aw_ready_o / lsu_aw_addr_i  in/out/in  1/1/ADDR_W  LSU write address
- lsu_w_valid_i / lsu_w_ready_o / lsu_w_data_i / lsu_w_strb_i  in/out/in/in  1/1/DATA_W/DATA_W/8  LSU write data
- lsu_b_valid_o / lsu_b_ready_i / lsu_b_resp_o  out/in/out  1/1/2  LSU write response
- mst_ar_valid_o / mst_ar_ready_i / mst_ar_addr_o  out/in/out  1/1/ADDR_W  master read address
- mst_r_valid_i / mst_r_ready_o / mst_r_data_i / mst_r_resp_i  in/out/in/in  1/1/DATA_W/2  master read response
- mst_aw_valid_o / mst_aw_ready_i / mst_aw_addr_o  out/in/out  1/1/ADDR_W  master write address
- mst_w_valid_o / mst_w_ready_i / mst_w_data_o / mst_w_strb_o  out/in/out/out  1/1/DATA_W/DATA_W/8  master write data
- mst_b_valid_i / mst_b_ready_o / mst_b_resp_i  in/out/in  1/1/2  master write response

## Operation
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP. Reset state is IDLE.
- Only one transaction is outstanding at a time, read or write, across both requesters.
- IDLE, LSU candidate:
  - An LSU write is a candidate when lsu_aw_valid_i && lsu_w_valid_i.
  - Otherwise an LSU read is a candidate when lsu_ar_valid_i.
  - An LSU write beats an LSU read.
- IDLE, arbitration:
  - If both IFU and an LSU candidate are present, the requester named by the priority bit wins. prio_lsu resets to 0, so IFU wins first.
  - On each grant, prio_lsu is set to (winner == IFU).
  - With a single requester present, it wins regardless of prio_lsu.
- Grant effects (in the IDLE cycle):
  - The winner's ready outputs are asserted combinationally in that cycle.
  - For a write, both lsu_aw_ready_o and lsu_w_ready_o are asserted.
  - Address, data and strobe are latched, and the owner is recorded.
  - Next state is RD_ADDR for a read or WR_REQ for a write.
- RD_ADDR: mst_ar_valid_o=1 with the latched address. On mst_ar_ready_i, go to RD_DATA.
- RD_DATA routing:
  - The owner's r_valid_o is mst_r_valid_i; the other requester's r_valid_o is 0.
  - mst_r_ready_o is the owner's r_ready_i.
  - r_data and r_resp pass through unchanged.
  - On the r handshake, go to IDLE.
- WR_REQ:
  - mst_aw_valid_o and mst_w_valid_o are asserted independently.
  - Each drops after its own handshake; sticky flags aw_done and w_done record this.
  - Go to WR_RESP in the cycle both are done, including the case where both handshakes happen in the same cycle.
- WR_RESP:
  - lsu_b_valid_o is mst_b_valid_i; mst_b_ready_o is lsu_b_ready_i; bresp passes through.
  - On the b handshake, go to IDLE and clear the flags.
- Error responses (resp≠00) are forwarded unchanged; no retry.
- All requester ready outputs are 0 outside IDLE.

## Timing
- Reset values: all *_valid_o, *_ready_o and mst_*_ready_o are 0; address/data/strb registers are 0; prio_lsu=0; flags are 0.
- Reset asserted mid-transaction: immediate return to IDLE with all valids 0; the in-flight transaction is dropped.
- Request accepted in cycle N: master valid is asserted in cycle N+1 (registered).
- Zero-wait slave, read: data is returned to the requester no earlier than N+2.
- Zero-wait slave, write: b is returned to the requester no earlier than N+2.
- The FSM re-enters IDLE the cycle after the response handshake; the next grant can occur in that IDLE cycle.
- Back-to-back throughput is one transaction per 3 cycles minimum.
- Master valids stay asserted until their handshake completes, whatever the requester inputs do.
- Response paths are combinational pass-throughs, with no added latency.

## Test plan
- Single IFU read of 0x8000_0000, slave returns 0x0000_0413 with rresp=00:
  - ifu_ar_ready_o=1 in cycle 0;
  - mst_ar_addr_o=0x8000_0000 with valid in cycle 1;
  - ifu_r_data_o=0x0000_0413 on the r handshake;
  - lsu_r_valid_o stays 0 throughout.
- IFU and LSU reads requested together, repeatedly, from reset:
  - grant order is IFU, LSU, IFU, LSU;
  - each requester sees only its own data (IFU 0x11, LSU 0x22).
- LSU write of addr 0x8000_1000, data 0xDEAD_BEEF, strb 0xF, with the slave holding wready low 3 cycles after awready:
  - mst_aw_valid_o drops after its handshake;
  - mst_w_valid_o is held until wready;
  - lsu_b_resp_o=00 is delivered once.
- LSU asserts a write and a read simultaneously:
  - the write is granted first;
  - lsu_ar_ready_o=0 until the arbiter returns to IDLE.
- Slave returns rresp=10 on an LSU read: lsu_r_resp_o=10 is passed through and the FSM returns to IDLE.
- Reset asserted during RD_DATA with the slave stalled: all valid and ready outputs are 0 immediately; after release, a fresh IFU read completes normally.
